// File: rtl/decode_scoreboard_pkg.sv
// Shared types for the decode-stage register scoreboard: register index,
// producer tag and the per-register tracking entry.
package decode_scoreboard_pkg;

  localparam int SB_NREG   = 32;
  localparam int SB_PEND_W = 2;
  localparam int SB_TAG_W  = 4;
  localparam int SB_RA_W   = $clog2(SB_NREG);

  typedef logic [SB_RA_W-1:0]   ra_t;
  typedef logic [SB_TAG_W-1:0]  sb_tag_t;
  typedef logic [SB_PEND_W-1:0] sb_cnt_t;

  // Counter value at which a register cannot take another outstanding write.
  localparam sb_cnt_t SB_CNT_MAX = '1;

  typedef struct packed {
    sb_cnt_t cnt;
    sb_tag_t tag;
    logic    ready;
  } sb_entry_t;

  function automatic logic sb_cnt_full(input sb_cnt_t cnt);
    return cnt == SB_CNT_MAX;
  endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode / bypass / writeback signals seen by the scoreboard. The master side
// is the pipeline around it, the slave side is the scoreboard itself.
interface decode_scoreboard_if #(
  parameter int RA_W  = 5,
  parameter int TAG_W = 4
);
  logic             issue_valid;
  logic             issue_ready;
  logic [RA_W-1:0]  rs1;
  logic [RA_W-1:0]  rs2;
  logic             use_rs1;
  logic             use_rs2;
  logic [RA_W-1:0]  rd;
  logic             rd_wen;
  logic             fast;
  logic [TAG_W-1:0] issue_tag;
  logic             src1_fwd;
  logic             src2_fwd;
  logic             fwd_valid;
  logic [RA_W-1:0]  fwd_rd;
  logic [TAG_W-1:0] fwd_tag;
  logic             wb_valid;
  logic [RA_W-1:0]  wb_rd;
  logic             flush;

  modport master (
    output issue_valid, rs1, rs2, use_rs1, use_rs2, rd, rd_wen, fast,
    output fwd_valid, fwd_rd, fwd_tag, wb_valid, wb_rd, flush,
    input  issue_ready, issue_tag, src1_fwd, src2_fwd
  );

  modport slave (
    input  issue_valid, rs1, rs2, use_rs1, use_rs2, rd, rd_wen, fast,
    input  fwd_valid, fwd_rd, fwd_tag, wb_valid, wb_rd, flush,
    output issue_ready, issue_tag, src1_fwd, src2_fwd
  );

endinterface

// File: rtl/decode_scoreboard_sb_src_check.sv
// Per-operand hazard check: decides whether one source must stall, take the
// bypass, or read the register file, given that register's scoreboard entry.
module sb_src_check
  import decode_scoreboard_pkg::*;
(
  input  logic    use_i,
  input  ra_t     rs_i,
  input  sb_cnt_t cnt_i,
  input  logic    ready_i,
  input  logic    wb_valid_i,
  input  ra_t     wb_rd_i,
  output logic    blocked_o,
  output logic    fwd_o
);

  logic write_through;
  logic tracked;

  // The last outstanding write landing this cycle makes the register file
  // copy current, so neither a stall nor the bypass is needed.
  assign write_through = wb_valid_i && (wb_rd_i == rs_i) && (cnt_i == sb_cnt_t'(1));

  assign tracked   = use_i && (rs_i != '0) && (cnt_i != '0) && !write_through;
  assign blocked_o = tracked && !ready_i;
  assign fwd_o     = tracked && ready_i;

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: pending-write counter, youngest producer
// tag and bypass-ready bit per architectural register.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int NREG   = SB_NREG,
  parameter int PEND_W = SB_PEND_W,
  parameter int TAG_W  = SB_TAG_W,
  parameter int RA_W   = $clog2(NREG)
) (
  input logic                clk,
  input logic                reset,
  decode_scoreboard_if.slave sb_if
);

  sb_entry_t        sb_q [NREG];
  sb_entry_t        sb_d [NREG];
  logic [TAG_W-1:0] tag_gen_q;
  logic [TAG_W-1:0] tag_gen_d;

  logic             src_use     [2];
  ra_t              src_rs      [2];
  logic             src_blocked [2];
  logic             src_fwd     [2];

  sb_cnt_t          rd_cnt;
  logic             rd_full;
  logic             issue_ready;
  logic             accept;

  assign src_use[0] = sb_if.use_rs1;
  assign src_use[1] = sb_if.use_rs2;
  assign src_rs[0]  = sb_if.rs1;
  assign src_rs[1]  = sb_if.rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    sb_src_check u_src_check (
      .use_i      (src_use[gi]),
      .rs_i       (src_rs[gi]),
      .cnt_i      (sb_q[src_rs[gi]].cnt),
      .ready_i    (sb_q[src_rs[gi]].ready),
      .wb_valid_i (sb_if.wb_valid),
      .wb_rd_i    (sb_if.wb_rd),
      .blocked_o  (src_blocked[gi]),
      .fwd_o      (src_fwd[gi])
    );
  end

  // A full counter stalls even if a writeback lands the same cycle; the
  // issue goes through on the following cycle once the counter has dropped.
  assign rd_cnt  = sb_q[sb_if.rd].cnt;
  assign rd_full = sb_if.rd_wen && (sb_if.rd != '0) && sb_cnt_full(rd_cnt);

  assign issue_ready = !sb_if.flush && !src_blocked[0] && !src_blocked[1] && !rd_full;
  assign accept      = sb_if.issue_valid && issue_ready;
  assign tag_gen_d   = accept ? tag_gen_q + 1'b1 : tag_gen_q;

  assign sb_if.issue_ready = issue_ready;
  assign sb_if.issue_tag   = tag_gen_q;
  assign sb_if.src1_fwd    = src_fwd[0];
  assign sb_if.src2_fwd    = src_fwd[1];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_x0
      assign sb_d[gi] = '0;
    end else begin : g_track
      logic              iss;
      logic              wb;
      logic              fw;
      logic [PEND_W-1:0] cnt_dec;
      logic [PEND_W-1:0] cnt_n;
      sb_entry_t         entry_next;

      always_comb begin
        iss = accept && sb_if.rd_wen && (sb_if.rd == RA_W'(gi));
        wb  = sb_if.wb_valid && (sb_if.wb_rd == RA_W'(gi));
        fw  = sb_if.fwd_valid && (sb_if.fwd_rd == RA_W'(gi))
              && (sb_if.fwd_tag == sb_q[gi].tag) && (sb_q[gi].cnt != '0);

        // Retire first (saturating), then count the new producer, so a
        // same-cycle issue and writeback leave an outstanding count unchanged.
        cnt_dec = (wb && (sb_q[gi].cnt != '0)) ? sb_q[gi].cnt - 1'b1 : sb_q[gi].cnt;
        cnt_n   = iss ? cnt_dec + 1'b1 : cnt_dec;

        entry_next = sb_q[gi];
        if (sb_if.flush) begin
          entry_next.cnt   = '0;
          entry_next.ready = 1'b0;
        end else begin
          entry_next.cnt = cnt_n;
          if (iss) begin
            entry_next.tag   = tag_gen_q;
            entry_next.ready = sb_if.fast;
          end else if (cnt_n == '0) begin
            entry_next.ready = 1'b0;
          end else if (fw) begin
            entry_next.ready = 1'b1;
          end
        end
      end

      assign sb_d[gi] = entry_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        sb_q[i] <= '0;
      end
      tag_gen_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        sb_q[i] <= sb_d[i];
      end
      tag_gen_q <= tag_gen_d;
    end
  end

endmodule
